// File: rtl/i2s_rx_core.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// i2s_rx_core
// Slave-mode I2S receiver. The bit clock, word select and serial data of an
// external master are oversampled in the clk_i domain. One word per channel
// slot is assembled and handed out on a valid/ready stream with a channel tag.
//
// Optional feature macro: I2S_RX_OVF_EN
//   defined   -> adds ovf_o (sticky overflow flag) and ovf_clr_i
//   undefined -> overflow drops are silent; data behaviour is identical
//
// Ports
//   clk_i, rst_n_i   system clock (>= 4x sck), asynchronous active-low reset
//   en_i             receiver enable
//   lsb_i            0 = MSB-first, 1 = LSB-first
//   fmt_i            00 = Philips, 01 = left-justified, 1x = Philips
//   chl_i            word length 00/01/10/11 = 8/16/24/32 bits
//   busy_o           a slot is being captured (SKIP or CAPT)
//   chd_o            channel of the word on rx_data_o (0 = left, 1 = right)
//   rx_valid_o/rx_ready_i/rx_data_o  output stream, data MSB-aligned
//   i2s_sck_i, i2s_ws_i, i2s_sd_i    I2S pins from the master
// ----------------------------------------------------------------------------
module i2s_rx_core #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  lsb_i,
    input  logic [1:0]            fmt_i,
    input  logic [1:0]            chl_i,
    output logic                  busy_o,
    output logic                  chd_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    input  logic                  i2s_sck_i,
    input  logic                  i2s_ws_i,
    input  logic                  i2s_sd_i
`ifdef I2S_RX_OVF_EN
    ,
    output logic                  ovf_o,
    input  logic                  ovf_clr_i
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_SKIP,
        S_CAPT,
        S_HOLD
    } state_t;

    // Word bit that receives the k-th serial bit, already MSB-aligned in the
    // 32-bit output: MSB-first lands at 31-k, LSB-first at (32-N)+k.
    function automatic logic [4:0] bit_index(input logic       lsb,
                                             input logic [1:0] chl,
                                             input logic [4:0] k);
        logic [4:0] base;
        base = {~chl, 3'b000};
        return lsb ? (base + k) : (5'd31 - k);
    endfunction

    logic [SYNC_STAGES-1:0] r_sck_sync, r_ws_sync, r_sd_sync;
    logic                   r_sck_d;
    logic                   r_ws_prev;
    logic [1:0]             r_chl;
    logic                   r_lsb;
    logic                   r_ch;
    state_t                 r_state;
    logic [4:0]             r_cnt;
    logic [DATA_WIDTH-1:0]  r_word;
    logic                   r_valid;
    logic                   r_chd;
    logic [DATA_WIDTH-1:0]  r_data;

    logic                   w_sck, w_ws, w_sd;
    logic                   w_sck_re, w_ws_edge;
    logic [1:0]             w_chl;
    logic                   w_lsb, w_lj, w_ch;
    state_t                 w_state_next;
    logic                   w_clr, w_cap, w_commit;
    logic [4:0]             w_cnt_base, w_cnt_next, w_idx;
    logic [DATA_WIDTH-1:0]  w_word_next;
    logic                   w_load;

    assign w_sck     = r_sck_sync[SYNC_STAGES-1];
    assign w_ws      = r_ws_sync[SYNC_STAGES-1];
    assign w_sd      = r_sd_sync[SYNC_STAGES-1];
    assign w_sck_re  = w_sck & ~r_sck_d;
    assign w_ws_edge = w_sck_re & (w_ws != r_ws_prev);

    // Configuration latched at a ws edge applies to the slot starting on that
    // very sck_re, so the edge cycle uses the live inputs.
    assign w_chl = w_ws_edge ? chl_i : r_chl;
    assign w_lsb = w_ws_edge ? lsb_i : r_lsb;
    assign w_ch  = w_ws_edge ? w_ws  : r_ch;
    assign w_lj  = (fmt_i == 2'b01);

    // Pin synchroniser and edge detection
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sck_sync <= '0;
            r_ws_sync  <= '0;
            r_sd_sync  <= '0;
            r_sck_d    <= 1'b0;
            r_ws_prev  <= 1'b0;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i2s_sck_i};
            r_ws_sync  <= {r_ws_sync[SYNC_STAGES-2:0],  i2s_ws_i};
            r_sd_sync  <= {r_sd_sync[SYNC_STAGES-2:0],  i2s_sd_i};
            r_sck_d    <= w_sck;
            if (w_sck_re) begin
                r_ws_prev <= w_ws;
            end
        end
    end

    // Slot configuration
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_chl <= 2'b00;
            r_lsb <= 1'b0;
            r_ch  <= 1'b0;
        end else if (w_ws_edge) begin
            r_chl <= chl_i;
            r_lsb <= lsb_i;
            r_ch  <= w_ws;
        end
    end

    // Capture FSM state, bit counter and word under assembly
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_word  <= w_word_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clr        = 1'b0;
        w_cap        = 1'b0;
        if (!en_i) begin
            w_state_next = S_IDLE;
            w_clr        = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: w_state_next = S_SYNC;
                default: begin
                    // Any ws edge starts a fresh slot; a partial word in
                    // progress is dropped by clearing it here.
                    if (w_ws_edge) begin
                        w_clr = 1'b1;
                        if (w_lj) begin
                            w_cap        = 1'b1;
                            w_state_next = S_CAPT;
                        end else begin
                            w_state_next = S_SKIP;
                        end
                    end else if (w_sck_re &&
                                 (r_state == S_SKIP || r_state == S_CAPT)) begin
                        // In Philips mode the ws-edge bit still carries the
                        // previous word's LSB; SKIP covers it and the first
                        // data bit arrives on the sck_re that leaves SKIP.
                        w_cap        = 1'b1;
                        w_state_next = S_CAPT;
                    end
                end
            endcase
        end

        w_cnt_base = w_clr ? 5'd0 : r_cnt;
        w_commit   = w_cap && (w_cnt_base == {w_chl, 3'b111});
        if (w_commit) begin
            w_state_next = S_HOLD;
        end
        w_cnt_next = w_cap ? (w_cnt_base + 5'd1) : w_cnt_base;

        w_idx       = bit_index(w_lsb, w_chl, w_cnt_base);
        w_word_next = w_clr ? '0 : r_word;
        if (w_cap) begin
            w_word_next[w_idx] = w_sd;
        end
    end

    // Output stream: a commit is loaded only when the holding slot is free
    // or being emptied in the same cycle; otherwise it is dropped.
    assign w_load = w_commit && (!r_valid || rx_ready_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid <= 1'b0;
            r_chd   <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_chd   <= w_ch;
            r_data  <= w_word_next;
        end else if (r_valid && rx_ready_i) begin
            r_valid <= 1'b0;
        end
    end

`ifdef I2S_RX_OVF_EN
    logic r_ovf;

    // Set has priority over clear
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ovf <= 1'b0;
        end else if (w_commit && r_valid && !rx_ready_i) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr_i) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf_o = r_ovf;
`endif

    assign busy_o     = (r_state == S_SKIP) || (r_state == S_CAPT);
    assign chd_o      = r_chd;
    assign rx_valid_o = r_valid;
    assign rx_data_o  = r_data;

endmodule

// File: tb/tb_i2s_rx_core.sv
`timescale 1ns/1ps
module tb_i2s_rx_core;

    localparam int CLK = 10;
    localparam int SS  = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        lsb   = 1'b0;
    logic [1:0]  fmt   = 2'b00;
    logic [1:0]  chl   = 2'b00;
    logic        ready = 1'b0;
    logic        sck   = 1'b0;
    logic        ws    = 1'b0;
    logic        sd    = 1'b0;
    logic        busy, chd, valid;
    logic [31:0] data;
`ifdef I2S_RX_OVF_EN
    logic        ovf_clr = 1'b0;
    logic        ovf;
`endif

    i2s_rx_core #(.DATA_WIDTH(32), .SYNC_STAGES(SS)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .en_i       (en),
        .lsb_i      (lsb),
        .fmt_i      (fmt),
        .chl_i      (chl),
        .busy_o     (busy),
        .chd_o      (chd),
        .rx_valid_o (valid),
        .rx_ready_i (ready),
        .rx_data_o  (data),
        .i2s_sck_i  (sck),
        .i2s_ws_i   (ws),
        .i2s_sd_i   (sd)
`ifdef I2S_RX_OVF_EN
        ,
        .ovf_o      (ovf),
        .ovf_clr_i  (ovf_clr)
`endif
    );

    always #(CLK/2) clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] d;
        logic        c;
        time         t;
    } rx_t;
    rx_t mon_q[$];

    time  rise_t, last_t;
    logic busy_before, busy_after;
    logic s_valid, s_chd, s_busy, s_ovf;
    logic [31:0] s_data;

    // Record every accepted word, sampled mid-cycle
    always @(negedge clk) begin
        #2;
        if (rst_n && valid && ready)
            mon_q.push_back('{d: data, c: chd, t: $time - 2});
    end

    // Reference: an N-bit word appears MSB-aligned with zero padding
    function automatic logic [31:0] align(input logic [31:0] w, input int n);
        logic [63:0] m;
        m = ({32'h0, w} & ((64'd1 << n) - 64'd1)) << (32 - n);
        return m[31:0];
    endfunction

    // One bit period of the master: 4 clk low, 4 clk high; ws/sd change while low.
    // hook 1: raise en, 2: drop en (sample busy around it), 3: async reset pulse
    task automatic drive_bit(input logic w, input logic s, input int hook);
        sck = 1'b0;
        ws  = w;
        sd  = s;
        if (hook == 1) en = 1'b1;
        if (hook == 2) begin
            busy_before = busy;
            en = 1'b0;
        end
        if (hook == 3) begin
            #3 rst_n = 1'b0;
            #1;
            s_valid = valid; s_data = data; s_chd = chd; s_busy = busy;
`ifdef I2S_RX_OVF_EN
            s_ovf = ovf;
`else
            s_ovf = 1'b0;
`endif
            @(negedge clk);
            @(negedge clk);
            #3 rst_n = 1'b1;
            @(negedge clk);
            @(negedge clk);
        end else begin
            @(negedge clk);
            if (hook == 2) busy_after = busy;
            repeat (3) @(negedge clk);
        end
        sck    = 1'b1;
        rise_t = $time;
        repeat (4) @(negedge clk);
    endtask

    // One ws slot carrying `word` serialised per the current lsb/fmt/chl.
    // Philips data lags ws by one bit; padding bits are random.
    task automatic send_slot(input logic w, input logic [31:0] word, input int slot,
                             input int hook_at, input int hook);
        int   n;
        logic lj;
        logic b;
        n  = 8 * (int'(chl) + 1);
        lj = (fmt == 2'b01);
        for (int j = 0; j < slot; j++) begin
            int k;
            k = lj ? j : j - 1;
            if (k >= 0 && k < n) b = lsb ? word[k] : word[n-1-k];
            else                 b = 1'($urandom);
            drive_bit(w, b, (j == hook_at) ? hook : 0);
            if (k == n - 1) last_t = rise_t;
        end
    endtask

    // Re-enable the receiver and give it a short partial slot to discard
    task automatic start_stream();
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (2) @(negedge clk);
        send_slot(1'b1, $urandom, 4, -1, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
        total++; if (data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", data); end
        total++; if (chd !== 1'b0) begin bad++; $display("FAIL reset_chd got=%b exp=0", chd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef I2S_RX_OVF_EN
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_philips16();
        logic [31:0] exp_d[$];
        logic        exp_c[$];
        logic [31:0] w;
        time         tl, tr;
        fmt = 2'b00; chl = 2'b01; lsb = 1'b0; ready = 1'b1;
        mon_q.delete();
        start_stream();
        send_slot(1'b0, 32'hA5C3, 32, -1, 0); tl = last_t;
        exp_d.push_back(32'hA5C3_0000); exp_c.push_back(1'b0);
        send_slot(1'b1, 32'h1234, 32, -1, 0); tr = last_t;
        exp_d.push_back(32'h1234_0000); exp_c.push_back(1'b1);
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            send_slot(i[0], w, $urandom_range(17, 32), -1, 0);
            exp_d.push_back(align(w, 16)); exp_c.push_back(i[0]);
        end
        repeat (4) @(negedge clk);
        total++;
        if (mon_q.size() !== exp_d.size()) begin
            bad++; $display("FAIL philips16_count got=%0d exp=%0d", mon_q.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < mon_q.size(); i++) begin
            total++;
            if (mon_q[i].d !== exp_d[i] || mon_q[i].c !== exp_c[i]) begin
                bad++; $display("FAIL philips16_word%0d got=%h/%b exp=%h/%b", i, mon_q[i].d, mon_q[i].c, exp_d[i], exp_c[i]);
            end
        end
        if (mon_q.size() >= 2) begin
            total++;
            if (mon_q[0].t - tl !== 64'((SS + 1) * CLK)) begin
                bad++; $display("FAIL latency_left got=%0t exp=%0d", mon_q[0].t - tl, (SS + 1) * CLK);
            end
            total++;
            if (mon_q[1].t - tr !== 64'((SS + 1) * CLK)) begin
                bad++; $display("FAIL latency_right got=%0t exp=%0d", mon_q[1].t - tr, (SS + 1) * CLK);
            end
        end
    endtask

    task automatic test_lj_lsb8();
        logic [31:0] exp_d[$];
        logic        exp_c[$];
        logic [31:0] w;
        fmt = 2'b01; chl = 2'b00; lsb = 1'b1; ready = 1'b1;
        mon_q.delete();
        start_stream();
        send_slot(1'b0, 32'h01, 16, -1, 0);
        exp_d.push_back(32'h0100_0000); exp_c.push_back(1'b0);
        for (int i = 1; i < 6; i++) begin
            w = $urandom;
            send_slot(i[0], w, $urandom_range(8, 20), -1, 0);
            exp_d.push_back(align(w, 8)); exp_c.push_back(i[0]);
        end
        repeat (4) @(negedge clk);
        total++;
        if (mon_q.size() !== exp_d.size()) begin
            bad++; $display("FAIL lj8_count got=%0d exp=%0d", mon_q.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < mon_q.size(); i++) begin
            total++;
            if (mon_q[i].d !== exp_d[i] || mon_q[i].c !== exp_c[i]) begin
                bad++; $display("FAIL lj8_word%0d got=%h/%b exp=%h/%b", i, mon_q[i].d, mon_q[i].c, exp_d[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_overflow32();
        fmt = 2'b01; chl = 2'b11; lsb = 1'b0; ready = 1'b0;
        mon_q.delete();
        start_stream();
        send_slot(1'b0, 32'hDEADBEEF, 32, -1, 0);
        send_slot(1'b1, 32'h0BADF00D, 32, -1, 0);
        repeat (4) @(negedge clk);
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b exp=1", valid); end
        total++; if (data !== 32'hDEADBEEF) begin bad++; $display("FAIL ovf_hold_data got=%h exp=deadbeef", data); end
        total++; if (chd !== 1'b0) begin bad++; $display("FAIL ovf_hold_chd got=%b exp=0", chd); end
`ifdef I2S_RX_OVF_EN
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag_set got=%b exp=1", ovf); end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        @(negedge clk);
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_flag_clr got=%b exp=0", ovf); end
`endif
        ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (mon_q.size() !== 1) begin
            bad++; $display("FAIL ovf_accept_count got=%0d exp=1", mon_q.size());
        end else begin
            total++;
            if (mon_q[0].d !== 32'hDEADBEEF) begin bad++; $display("FAIL ovf_accept_data got=%h exp=deadbeef", mon_q[0].d); end
        end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b exp=0", valid); end
    endtask

    task automatic test_early_ws24();
        logic [31:0] w;
        fmt = 2'b00; chl = 2'b10; lsb = 1'b0; ready = 1'b1;
        mon_q.delete();
        start_stream();
        send_slot(1'b0, $urandom, 20, -1, 0);
        send_slot(1'b1, 32'hABCDEF, 32, -1, 0);
        w = $urandom;
        send_slot(1'b0, w, $urandom_range(25, 32), -1, 0);
        repeat (4) @(negedge clk);
        total++;
        if (mon_q.size() !== 2) begin
            bad++; $display("FAIL early24_count got=%0d exp=2", mon_q.size());
        end else begin
            total++;
            if (mon_q[0].d !== 32'hABCDEF00 || mon_q[0].c !== 1'b1) begin
                bad++; $display("FAIL early24_full got=%h/%b exp=abcdef00/1", mon_q[0].d, mon_q[0].c);
            end
            total++;
            if (mon_q[1].d !== align(w, 24) || mon_q[1].c !== 1'b0) begin
                bad++; $display("FAIL early24_next got=%h/%b exp=%h/0", mon_q[1].d, mon_q[1].c, align(w, 24));
            end
        end
    endtask

    task automatic test_enable();
        logic [31:0] wb;
        fmt = 2'b01; chl = 2'b01; lsb = 1'b0; ready = 1'b0;
        en = 1'b0;
        mon_q.delete();
        repeat (3) @(negedge clk);
        send_slot(1'b1, $urandom, 6, -1, 0);
        send_slot(1'b0, $urandom, 32, 5, 1);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL en_partial_valid got=%b exp=0", valid); end
        wb = $urandom;
        send_slot(1'b1, wb, 32, -1, 0);
        send_slot(1'b0, $urandom, 32, 10, 2);
        total++; if (busy_before !== 1'b1) begin bad++; $display("FAIL en_busy_before got=%b exp=1", busy_before); end
        total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL en_busy_after got=%b exp=0", busy_after); end
        repeat (4) @(negedge clk);
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL en_pending_valid got=%b exp=1", valid); end
        total++; if (data !== align(wb, 16)) begin bad++; $display("FAIL en_pending_data got=%h exp=%h", data, align(wb, 16)); end
        total++; if (chd !== 1'b1) begin bad++; $display("FAIL en_pending_chd got=%b exp=1", chd); end
        ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (mon_q.size() !== 1) begin
            bad++; $display("FAIL en_accept_count got=%0d exp=1", mon_q.size());
        end else begin
            total++;
            if (mon_q[0].d !== align(wb, 16)) begin bad++; $display("FAIL en_accept_data got=%h exp=%h", mon_q[0].d, align(wb, 16)); end
        end
        en = 1'b1;
    endtask

    task automatic test_async_reset();
        logic [31:0] wy, wz;
        fmt = 2'b01; chl = 2'b01; lsb = 1'b0; ready = 1'b0;
        mon_q.delete();
        start_stream();
        send_slot(1'b0, $urandom, 32, -1, 0);
        send_slot(1'b1, $urandom, 32, -1, 0);
        send_slot(1'b0, $urandom, 32, 6, 3);
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", s_valid); end
        total++; if (s_data !== 32'h0) begin bad++; $display("FAIL arst_data got=%h exp=0", s_data); end
        total++; if (s_chd !== 1'b0) begin bad++; $display("FAIL arst_chd got=%b exp=0", s_chd); end
        total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b exp=0", s_busy); end
        total++; if (s_ovf !== 1'b0) begin bad++; $display("FAIL arst_ovf got=%b exp=0", s_ovf); end
        total++; if (mon_q.size() !== 0) begin bad++; $display("FAIL arst_no_words got=%0d exp=0", mon_q.size()); end
        ready = 1'b1;
        wy = $urandom;
        wz = $urandom;
        send_slot(1'b1, wy, 32, -1, 0);
        send_slot(1'b0, wz, 32, -1, 0);
        repeat (4) @(negedge clk);
        total++;
        if (mon_q.size() !== 2) begin
            bad++; $display("FAIL arst_resume_count got=%0d exp=2", mon_q.size());
        end else begin
            total++;
            if (mon_q[0].d !== align(wy, 16) || mon_q[0].c !== 1'b1) begin
                bad++; $display("FAIL arst_resume_r got=%h/%b exp=%h/1", mon_q[0].d, mon_q[0].c, align(wy, 16));
            end
            total++;
            if (mon_q[1].d !== align(wz, 16) || mon_q[1].c !== 1'b0) begin
                bad++; $display("FAIL arst_resume_l got=%h/%b exp=%h/0", mon_q[1].d, mon_q[1].c, align(wz, 16));
            end
        end
    endtask

    initial begin
        test_reset();
        test_philips16();
        test_lj_lsb8();
        test_overflow32();
        test_early_ws24();
        test_enable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
